// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter using the request-to-send
//            sequence on open-drain ps2c/ps2d. Optional frame watchdog is
//            enabled by defining PS2_TX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 13000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RTS   = 3'd1;
    localparam logic [2:0] c_ST_START = 3'd2;
    localparam logic [2:0] c_ST_DATA  = 3'd3;
    localparam logic [2:0] c_ST_STOP  = 3'd4;

    localparam int               c_CNT_W    = $clog2(INHIBIT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_DLOW = c_CNT_W'(INHIBIT_CYCLES - 2);

    if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be >= 2");
    end

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [8:0]         r_b;
    logic [8:0]         w_b_next;
    logic [3:0]         r_n;
    logic [3:0]         w_n_next;
    logic               r_c_low;
    logic               r_d_low;
    logic               w_d_low_next;
    logic               r_ack_err;
    logic               w_ack_err_next;
    logic               w_done;
    logic [7:0]         r_filt;
    logic [7:0]         w_filt_next;
    logic               r_f_ps2c;
    logic               w_f_next;
    logic               w_fall;

    // Line drivers are register outputs so reset releases them asynchronously.
    assign ps2c = r_c_low ? 1'b0 : 1'bz;
    assign ps2d = r_d_low ? 1'b0 : 1'bz;

    assign w_filt_next = {ps2c, r_filt[7:1]};
    assign w_f_next    = (w_filt_next == 8'hFF) ? 1'b1 :
                         (w_filt_next == 8'h00) ? 1'b0 : r_f_ps2c;
    assign w_fall      = r_f_ps2c & ~w_f_next;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int                c_WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic [c_WD_W-1:0] r_wdog;
    logic [c_WD_W-1:0] w_wdog_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_wdog_next;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_b       <= '0;
            r_n       <= '0;
            r_c_low   <= 1'b0;
            r_d_low   <= 1'b0;
            r_ack_err <= 1'b0;
            r_filt    <= '0;
            r_f_ps2c  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_b       <= w_b_next;
            r_n       <= w_n_next;
            r_c_low   <= (w_state_next == c_ST_RTS);
            r_d_low   <= w_d_low_next;
            r_ack_err <= w_ack_err_next;
            r_filt    <= w_filt_next;
            r_f_ps2c  <= w_f_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_b_next       = r_b;
        w_n_next       = r_n;
        w_d_low_next   = r_d_low;
        w_ack_err_next = r_ack_err;
        w_done         = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_d_low_next = 1'b0;
                if (wr_ps2) begin
                    w_b_next     = {~^din, din};
                    w_cnt_next   = '0;
                    w_state_next = c_ST_RTS;
                end
            end
            c_ST_RTS: begin
                // Start bit goes out one cycle before the clock is released.
                if (r_cnt == c_CNT_DLOW) begin
                    w_d_low_next = 1'b1;
                end
                if (r_cnt == c_CNT_LAST) begin
                    w_state_next = c_ST_START;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            c_ST_START: begin
                if (w_fall) begin
                    w_d_low_next = ~r_b[0];
                    w_b_next     = {1'b0, r_b[8:1]};
                    w_n_next     = 4'd8;
                    w_state_next = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_fall) begin
                    if (r_n == 4'd0) begin
                        w_d_low_next = 1'b0;
                        w_state_next = c_ST_STOP;
                    end else begin
                        w_d_low_next = ~r_b[0];
                        w_b_next     = {1'b0, r_b[8:1]};
                        w_n_next     = r_n - 1'b1;
                    end
                end
            end
            c_ST_STOP: begin
                if (w_fall) begin
                    w_ack_err_next = ps2d;
                    w_done         = 1'b1;
                    w_state_next   = c_ST_IDLE;
                end
            end
            default: begin
                w_d_low_next = 1'b0;
                w_state_next = c_ST_IDLE;
            end
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        w_wdog_next = r_wdog;
        if (r_state == c_ST_RTS) begin
            w_wdog_next = '0;
        end else if (r_state == c_ST_START || r_state == c_ST_DATA || r_state == c_ST_STOP) begin
            // A completing edge in the final watchdog cycle still wins.
            if (r_wdog == c_WD_LAST && !(r_state == c_ST_STOP && w_fall)) begin
                w_state_next   = c_ST_IDLE;
                w_d_low_next   = 1'b0;
                w_ack_err_next = 1'b1;
                w_done         = 1'b1;
            end else begin
                w_wdog_next = r_wdog + 1'b1;
            end
        end
`endif
    end

    // Outputs
    always_comb begin
        tx_idle      = (r_state == c_ST_IDLE);
        tx_done_tick = w_done;
        ack_err      = r_ack_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Brief    : Directed bench for ps2_host_tx with a PS/2 device model that
//            clocks frames, reads bits on rising ps2c and optionally acks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INHIBIT = 20;
    localparam int TIMEOUT = 500;
    localparam int HALF    = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       ack_err;

    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;
    logic last_ack_err = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int inhibit_cnt = 0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .ack_err     (ack_err)
    );

    // Counts done pulses and host-driven clock-low cycles, sampled after each edge.
    always begin
        @(posedge clk);
        #1;
        if (tx_done_tick === 1'b1) done_cnt++;
        if (ps2c === 1'b0 && !dev_c_low) inhibit_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic dev_frame(input bit do_ack, input int abort_edge, input bit pulse_wr,
                             output logic [10:0] rx, output bit aborted);
        int t;
        rx = '0;
        aborted = 1'b0;
        t = 0;
        while (ps2c !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        check("rts_seen", t < 200, 1'b1);
        if (t >= 200) return;
        t = 0;
        while (ps2c !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        check("rts_release", t < 200, 1'b1);
        if (t >= 200) return;
        repeat (HALF) @(negedge clk);
        rx[0] = ps2d;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && do_ack) dev_d_low = 1'b1;
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
            @(negedge clk);
            if (k <= 10) rx[k] = ps2d;
            if (k == abort_edge) begin
                check("pre_reset_ps2d", ps2d, 1'b0);
                #2 reset = 1'b1;
                #1;
                check("abort_ps2d_rel", ps2d, 1'b1);
                check("abort_ps2c_rel", ps2c, 1'b1);
                check("abort_idle", tx_idle, 1'b1);
                check("abort_done", tx_done_tick, 1'b0);
                @(negedge clk);
                reset = 1'b0;
                aborted = 1'b1;
                return;
            end
            if (k == 3 && pulse_wr) begin
                din = 8'hAA;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
            repeat (HALF - 1) @(negedge clk);
        end
        dev_d_low = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] value, input logic exp_par, input bit do_ack,
                             input int abort_edge, input bit pulse_wr);
        logic [10:0] rx;
        bit aborted;
        int d0;
        int i0;
        d0 = done_cnt;
        i0 = inhibit_cnt;
        @(negedge clk);
        din = value;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        check("busy", tx_idle, 1'b0);
        check("ack_hold", ack_err, last_ack_err);
        dev_frame(do_ack, abort_edge, pulse_wr, rx, aborted);
        if (aborted) begin
            last_ack_err = 1'b0;
            repeat (20) @(negedge clk);
            return;
        end
        repeat (5) @(negedge clk);
        check("start_bit", rx[0], 1'b0);
        check("data", rx[8:1], value);
        check("parity", rx[9], exp_par);
        check("stop_bit", rx[10], 1'b1);
        check("inhibit_len", inhibit_cnt - i0, INHIBIT);
        check("done_pulses", done_cnt - d0, 1);
        check("ack_err", ack_err, !do_ack);
        check("idle_after", tx_idle, 1'b1);
        last_ack_err = !do_ack;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int t;
        int cyc;
        int d0;
        reset = 1'b1;
        wr_ps2 = 1'b0;
        din = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_idle", tx_idle, 1'b1);
        check("rst_done", tx_done_tick, 1'b0);
        check("rst_ack_err", ack_err, 1'b0);
        check("rst_ps2c", ps2c, 1'b1);
        check("rst_ps2d", ps2d, 1'b1);
        reset = 1'b0;
        repeat (12) @(negedge clk);

        run_frame(8'hED, 1'b1, 1'b1, 0, 1'b0);
        run_frame(8'hFF, 1'b1, 1'b1, 0, 1'b0);
        run_frame(8'h00, 1'b1, 1'b1, 0, 1'b0);
        run_frame(8'hF4, 1'b0, 1'b0, 0, 1'b0);
        run_frame(8'hF4, 1'b0, 1'b1, 0, 1'b0);
        run_frame(8'h55, 1'b1, 1'b1, 0, 1'b1);

        // Reset in the middle of request-to-send.
        @(negedge clk);
        din = 8'hED;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        repeat (4) @(negedge clk);
        check("rts_drive", ps2c, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("rts_rst_ps2c", ps2c, 1'b1);
        check("rts_rst_ps2d", ps2d, 1'b1);
        check("rts_rst_idle", tx_idle, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        last_ack_err = 1'b0;
        repeat (12) @(negedge clk);

        run_frame(8'hED, 1'b1, 1'b1, 5, 1'b0);
        run_frame(8'hED, 1'b1, 1'b1, 0, 1'b0);

        // Silent device: watchdog or indefinite wait in start.
        d0 = done_cnt;
        @(negedge clk);
        din = 8'hED;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        t = 0;
        while (ps2c !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        check("silent_release", t < 200, 1'b1);
        cyc = 1;
        while (tx_done_tick !== 1'b1 && cyc < 1000) begin @(negedge clk); cyc++; end
`ifdef PS2_TX_TIMEOUT_EN
        check("timeout_cycle", cyc, TIMEOUT);
        @(negedge clk);
        check("timeout_ack_err", ack_err, 1'b1);
        check("timeout_idle", tx_idle, 1'b1);
        check("timeout_ps2c", ps2c, 1'b1);
        check("timeout_ps2d", ps2d, 1'b1);
        check("timeout_pulses", done_cnt - d0, 1);
`else
        check("silent_wait", cyc, 1000);
        check("silent_busy", tx_idle, 1'b0);
        check("silent_pulses", done_cnt - d0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
